// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the control decoder.
// Operation codes, 3-bit opcodes and prep-mode predicates.
package isa_pkg;

    typedef enum logic [3:0] {
        INC  = 4'd0,
        DEC  = 4'd1,
        XOR  = 4'd2,
        XORR = 4'd3,
        SLL  = 4'd4,
        SRL  = 4'd5,
        HALT = 4'd6,
        ANDI = 4'd8,
        BEQ  = 4'd9,
        LW   = 4'd10,
        SW   = 4'd11,
        SAVE = 4'd12,
        PSFT = 4'd13,
        PXOR = 4'd14
    } enc_op_t;

    localparam logic [2:0] OPC_PREP   = 3'b000;
    localparam logic [2:0] OPC_INCDEC = 3'b001;
    localparam logic [2:0] OPC_XOR    = 3'b010;
    localparam logic [2:0] OPC_XORR   = 3'b011;
    localparam logic [2:0] OPC_SLL    = 3'b100;
    localparam logic [2:0] OPC_SRL    = 3'b101;
    localparam logic [2:0] OPC_HALT   = 3'b111;

    // Prepped ops live in the upper half of the op space; 15 is undefined.
    function automatic logic is_prepped(input logic [3:0] op);
        return op[3] && (op != 4'd15);
    endfunction

    function automatic logic clears_prep(input logic [3:0] op);
        return (op == ANDI) || (op == BEQ) || (op == LW) || (op == SW) || (op == SAVE);
    endfunction

    function automatic logic keeps_prep(input logic [3:0] op);
        return (op == PSFT) || (op == PXOR);
    endfunction

endpackage

// File: rtl/instr_word_fmt.sv
// Combinational formatter: abstract op plus fields to the PREP word and op word.
// Prep-mode legality is decided by the caller; only undefined ops are flagged here.
module instr_word_fmt
    import isa_pkg::*;
#(
    parameter int unsigned INSTR_W = 9
) (
    input  logic [3:0]         op,
    input  logic [2:0]         rd,
    input  logic [2:0]         rs,
    input  logic [5:0]         imm,
    output logic [INSTR_W-1:0] prep_word,
    output logic [INSTR_W-1:0] op_word,
    output logic               needs_prep,
    output logic               illegal
);

    logic [8:0] word9;

    always_comb begin
        word9   = '0;
        illegal = 1'b0;
        case (op)
            INC:  word9 = {OPC_INCDEC, rd, 2'b00, 1'b1};
            DEC:  word9 = {OPC_INCDEC, rd, 2'b00, 1'b0};
            XOR:  word9 = {OPC_XOR, rd, rs};
            XORR: word9 = {OPC_XORR, rd, rs};
            SLL:  word9 = {OPC_SLL, rd, rs};
            SRL:  word9 = {OPC_SRL, rd, rs};
            HALT: word9 = {OPC_HALT, 6'b000000};
            ANDI, BEQ, LW, SW, SAVE, PSFT, PXOR:
                  word9 = {op[2:0], rd, rs};
            default: illegal = 1'b1;
        endcase
    end

    assign needs_prep = is_prepped(op);
    assign prep_word  = INSTR_W'({OPC_PREP, imm});
    assign op_word    = INSTR_W'(word9);

endmodule

// File: rtl/instr_encoder.sv
// Encodes one abstract operation per request into the decoder's instruction stream,
// inserting PREP prefixes and tracking the decoder's prep mode.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [2:0]         req_rd,
    input  logic [2:0]         req_rs,
    input  logic [5:0]         req_imm,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic               prep_active,
    output logic               err,
    output logic [CNT_W-1:0]   words_emitted
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_EMIT_PREP = 2'd1;
    localparam logic [1:0] S_EMIT_OP   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pend_word_q, pend_word_d;
    logic               pend_set_q, pend_set_d;
    logic               pend_clr_q, pend_clr_d;
    logic               prep_active_q, prep_active_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   words_q, words_d;

    logic [INSTR_W-1:0] fmt_prep_word;
    logic [INSTR_W-1:0] fmt_op_word;
    logic               fmt_needs_prep;
    logic               fmt_illegal;
    logic               accept;
    logic               out_hs;

    instr_word_fmt #(
        .INSTR_W(INSTR_W)
    ) u_fmt (
        .op        (req_op),
        .rd        (req_rd),
        .rs        (req_rs),
        .imm       (req_imm),
        .prep_word (fmt_prep_word),
        .op_word   (fmt_op_word),
        .needs_prep(fmt_needs_prep),
        .illegal   (fmt_illegal)
    );

    assign accept = req_valid && req_ready_q;
    assign out_hs = instr_valid_q && instr_ready;

    always_comb begin
        state_d       = state_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pend_word_d   = pend_word_q;
        pend_set_d    = pend_set_q;
        pend_clr_d    = pend_clr_q;
        prep_active_d = prep_active_q;
        err_d         = 1'b0;
        words_d       = words_q + CNT_W'(out_hs);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // A non-prep op in prep mode cannot be expressed: it would decode as a prepped op.
                    if (fmt_illegal || (!fmt_needs_prep && prep_active_q)) begin
                        err_d = 1'b1;
                    end else begin
                        instr_valid_d = 1'b1;
                        pend_word_d   = fmt_op_word;
                        pend_set_d    = keeps_prep(req_op);
                        pend_clr_d    = clears_prep(req_op);
                        if (fmt_needs_prep && !prep_active_q) begin
                            state_d = S_EMIT_PREP;
                            instr_d = fmt_prep_word;
                        end else begin
                            state_d = S_EMIT_OP;
                            instr_d = fmt_op_word;
                        end
                    end
                end
            end
            S_EMIT_PREP: begin
                if (out_hs) begin
                    state_d = S_EMIT_OP;
                    instr_d = pend_word_q;
                end
            end
            S_EMIT_OP: begin
                if (out_hs) begin
                    state_d       = S_IDLE;
                    instr_valid_d = 1'b0;
                    if (pend_set_q) prep_active_d = 1'b1;
                    if (pend_clr_q) prep_active_d = 1'b0;
                end
            end
            default: begin
                state_d       = S_IDLE;
                instr_valid_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            pend_word_q   <= '0;
            pend_set_q    <= 1'b0;
            pend_clr_q    <= 1'b0;
            prep_active_q <= 1'b0;
            err_q         <= 1'b0;
            words_q       <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pend_word_q   <= pend_word_d;
            pend_set_q    <= pend_set_d;
            pend_clr_q    <= pend_clr_d;
            prep_active_q <= prep_active_d;
            err_q         <= err_d;
            words_q       <= words_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign instr_valid   = instr_valid_q;
    assign instr         = instr_q;
    assign prep_active   = prep_active_q;
    assign err           = err_q;
    assign words_emitted = words_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a queue-based stream model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_instr_encoder;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = '0;
    logic [2:0]    req_rd = '0;
    logic [2:0]    req_rs = '0;
    logic [5:0]    req_imm = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic [8:0]    instr;
    logic          prep_active;
    logic          err;
    logic [CW-1:0] words_emitted;

    instr_encoder #(
        .INSTR_W(9),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rd       (req_rd),
        .req_rs       (req_rs),
        .req_imm      (req_imm),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .prep_active  (prep_active),
        .err          (err),
        .words_emitted(words_emitted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int word;
        bit last;
        int eff;   // 0 none, 1 enter prep mode, 2 leave prep mode
    } exp_t;

    exp_t exp_q[$];
    exp_t e_pop;
    exp_t e_new;
    int   log_q[$];
    int   m_prep = 0;
    int   m_cnt = 0;
    bit   m_err = 0;
    bit   after_rst = 0;
    bit   started = 0;
    int   err_pulses = 0;
    int   m_op, m_rd, m_rs, m_w;
    bit   m_prepped, m_plain;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Check current outputs, then advance the model by what the next posedge will do.
    always @(negedge clk) begin
        if (started) begin
            chk("instr_valid", instr_valid, (exp_q.size() != 0));
            if (exp_q.size() != 0) chk("instr", instr, exp_q[0].word);
            else if (after_rst)    chk("instr_after_reset", instr, 0);
            chk("prep_active", prep_active, m_prep);
            chk("err", err, m_err);
            chk("words_emitted", words_emitted, m_cnt);
            chk("req_ready", req_ready, after_rst ? 0 : (exp_q.size() == 0));
            if (err === 1'b1) err_pulses++;
        end
        if (reset) begin
            exp_q.delete();
            m_prep    = 0;
            m_cnt     = 0;
            m_err     = 0;
            after_rst = 1;
            started   = 1;
        end else begin
            after_rst = 0;
            m_err     = 0;
            if (instr_valid === 1'b1 && instr_ready) begin
                log_q.push_back(int'(instr));
                m_cnt = (m_cnt + 1) % (1 << CW);
                if (exp_q.size() != 0) begin
                    e_pop = exp_q.pop_front();
                    if (e_pop.last && e_pop.eff == 1) m_prep = 1;
                    if (e_pop.last && e_pop.eff == 2) m_prep = 0;
                end
            end
            if (req_valid && req_ready === 1'b1) begin
                m_op = int'(req_op);
                m_rd = int'(req_rd);
                m_rs = int'(req_rs);
                m_prepped = (m_op >= 8) && (m_op <= 14);
                m_plain   = (m_op <= 6);
                if (!(m_prepped || (m_plain && m_prep == 0))) begin
                    m_err = 1;
                end else begin
                    if (m_op <= 1)      m_w = 64 + m_rd * 8 + ((m_op == 0) ? 1 : 0);
                    else if (m_op == 6) m_w = 7 * 64;
                    else if (m_prepped) m_w = (m_op - 8) * 64 + m_rd * 8 + m_rs;
                    else                m_w = m_op * 64 + m_rd * 8 + m_rs;
                    if (m_prepped && m_prep == 0) begin
                        e_new.word = int'(req_imm);
                        e_new.last = 0;
                        e_new.eff  = 0;
                        exp_q.push_back(e_new);
                    end
                    e_new.word = m_w;
                    e_new.last = 1;
                    e_new.eff  = (m_op >= 13) ? 1 : (m_prepped ? 2 : 0);
                    exp_q.push_back(e_new);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int op, input int rd, input int rs, input int imm);
        bit ok = 0;
        req_op    = op[3:0];
        req_rd    = rd[2:0];
        req_rs    = rs[2:0];
        req_imm   = imm[5:0];
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) ok = 1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (req_ready === 1'b1 && instr_valid === 1'b0) ok = 1;
            else tick(1);
        end
        chk("drain_idle", ok, 1);
    endtask

    int base;
    int ep;

    initial begin
        tick(3);
        reset = 1'b0;
        chk("reset_valid", instr_valid, 0);
        chk("reset_words", words_emitted, 0);
        tick(1);

        // LW with prefix
        base = log_q.size();
        send(10, 2, 5, 'h2A);
        drain();
        chk("lw_count", log_q.size() - base, 2);
        chk("lw_w0", log_q[base], 'h02A);
        chk("lw_w1", log_q[base + 1], 'h095);
        chk("lw_prep", prep_active, 0);
        chk("lw_words", words_emitted, 2);

        // INC / DEC, one cycle of req_ready low each
        base = log_q.size();
        send(0, 3, 0, 0);
        chk("inc_ready_lo", req_ready, 0);
        tick(1);
        chk("inc_ready_hi", req_ready, 1);
        send(1, 3, 0, 0);
        chk("dec_ready_lo", req_ready, 0);
        tick(1);
        chk("dec_ready_hi", req_ready, 1);
        chk("incdec_count", log_q.size() - base, 2);
        chk("inc_word", log_q[base], 'h059);
        chk("dec_word", log_q[base + 1], 'h058);

        // PSFT enters prep mode, ANDI uses it without a second PREP
        base = log_q.size();
        send(13, 1, 0, 'h05);
        drain();
        chk("psft_prep_on", prep_active, 1);
        send(8, 4, 2, 'h3F);
        drain();
        chk("psft_andi_count", log_q.size() - base, 3);
        chk("psft_w0", log_q[base], 'h005);
        chk("psft_w1", log_q[base + 1], 'h148);
        chk("andi_w", log_q[base + 2], 'h022);
        chk("andi_prep_off", prep_active, 0);

        // Rejections
        send(14, 0, 0, 0);
        drain();
        chk("pxor_prep_on", prep_active, 1);
        ep = err_pulses;
        base = log_q.size();
        send(2, 1, 1, 0);
        tick(3);
        chk("xor_err_pulses", err_pulses - ep, 1);
        chk("xor_no_word", log_q.size() - base, 0);
        chk("xor_prep_kept", prep_active, 1);
        send(12, 0, 0, 0);
        drain();
        chk("save_count", log_q.size() - base, 1);
        chk("save_word", log_q[base], 'h100);
        chk("save_prep_off", prep_active, 0);
        ep = err_pulses;
        base = log_q.size();
        send(7, 1, 1, 1);
        tick(3);
        chk("op7_err_pulses", err_pulses - ep, 1);
        chk("op7_no_word", log_q.size() - base, 0);

        // SW with back-pressure on both words
        instr_ready = 1'b0;
        base = log_q.size();
        send(11, 0, 7, 'h10);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("sw_hold_prep", instr, 'h010);
            chk("sw_ready_lo0", req_ready, 0);
        end
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("sw_hold_op", instr, 'h0C7);
            chk("sw_ready_lo1", req_ready, 0);
        end
        instr_ready = 1'b1;
        tick(1);
        chk("sw_count", log_q.size() - base, 2);
        chk("sw_w1", log_q[base + 1], 'h0C7);

        // Reset while the op word is pending
        base = log_q.size();
        send(10, 2, 5, 'h2A);
        tick(1);
        chk("abort_pending", instr, 'h095);
        instr_ready = 1'b0;
        reset = 1'b1;
        tick(1);
        chk("abort_valid", instr_valid, 0);
        chk("abort_instr", instr, 0);
        chk("abort_ready", req_ready, 0);
        chk("abort_prep", prep_active, 0);
        chk("abort_err", err, 0);
        chk("abort_words", words_emitted, 0);
        reset = 1'b0;
        instr_ready = 1'b1;
        tick(1);
        send(0, 3, 0, 0);
        drain();
        chk("abort_count", log_q.size() - base, 2);
        chk("abort_w0", log_q[base], 'h02A);
        chk("abort_next", log_q[base + 1], 'h059);

        // HALT repeatedly; counter wraps (1 + 18 = 19 -> 3 mod 16)
        for (int i = 0; i < 18; i++) begin
            send(6, 5, 5, 0);
            drain();
        end
        chk("halt_word", log_q[log_q.size() - 1], 'h1C0);
        chk("wrap_words", words_emitted, 3);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the control decoder. It accepts one abstract operation per handshake and emits the 9-bit instruction word(s) the decoder expects on a valid/ready instruction stream.
- It inserts the PREP prefix (opcode 000, 6-bit immediate) automatically and mirrors the decoder's prep-mode state, so the emitted stream always decodes to the requested operation.
- It sits between the test-program generator or host loader and the instruction memory write port.

Parameters:
- INSTR_W, 9, instruction word width; opcode is bits [8:6], operand is bits [5:0].
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request this cycle.
- req_op  in  4  operation code, enc_op_t (see Decomposition).
- req_rd  in  3  destination/first register field.
- req_rs  in  3  source/second register field.
- req_imm  in  6  immediate loaded by the PREP prefix.
- instr_valid  out  1  instr holds a valid word.
- instr_ready  in  1  consumer accepts the word.
- instr  out  INSTR_W  emitted instruction word.
- prep_active  out  1  decoder is now in prep mode (mirror).
- err  out  1  one-cycle pulse: request rejected.
- words_emitted  out  CNT_W  count of completed output handshakes; wraps.

Behaviour:
- Reset values: all outputs 0; state IDLE; prep_active=0; words_emitted=0. Reset aborts any pending word, which is never emitted.
- FSM states: IDLE, EMIT_PREP, EMIT_OP. Outputs are registered. req_ready=1 only in IDLE.
- Word formats:
  - PREP: {000, imm[5:0]}.
  - INC/DEC: {001, rd, 00, dir}, with dir=1 for INC and dir=0 for DEC.
  - Other ops: {opc, rd, rs}.
- Non-prep mapping: INC/DEC→001, XOR→010, XORR→011, SLL→100, SRL→101, HALT→111 with rd=rs=0.
- Prepped ops (req_op[3]=1): opcode = req_op[2:0]. ANDI 000, BEQ 001, LW 010, SW 011, SAVE 100, PSFT 101, PXOR 110.
- Acceptance at cycle N (req_valid & req_ready):
  - Prepped op with prep_active=0 → EMIT_PREP. The PREP word is valid at N+1. On its handshake → EMIT_OP, and the op word is valid the next cycle.
  - Prepped op with prep_active=1 → EMIT_OP directly. No PREP is emitted, because 000 would decode as ANDI. req_imm is ignored.
  - Non-prep op with prep_active=0 → EMIT_OP, op word valid at N+1.
  - Non-prep op with prep_active=1 → request consumed, err=1 at N+1, nothing emitted, state stays IDLE.
  - Undefined req_op (7, 15) → same as the previous case: consumed, err=1 at N+1, nothing emitted.
- While instr_valid=1 and instr_ready=0, instr is held stable and no new request is accepted.
- On the op-word handshake:
  - PSFT/PXOR set prep_active=1.
  - ANDI/BEQ/LW/SW/SAVE clear prep_active.
  - Non-prep ops leave prep_active at 0.
  - FSM returns to IDLE; req_ready=1 the following cycle.
- instr_valid drops on the cycle after a handshake unless the FSM moves to the next word.
- Throughput: 1 word per 2 cycles.
- words_emitted increments on every output handshake and wraps from 2^CNT_W-1 to 0.
- HALT is encoded like any other op; the encoder does not stop after it.

Decomposition:
- Package isa_pkg holds:
  - enc_op_t enum: INC=0, DEC=1, XOR=2, XORR=3, SLL=4, SRL=5, HALT=6, ANDI=8, BEQ=9, LW=10, SW=11, SAVE=12, PSFT=13, PXOR=14.
  - Opcode constants: OPC_PREP=3'b000 … OPC_HALT=3'b111.
  - Predicate functions is_prepped, clears_prep, keeps_prep.
  - The package is shared with controldecoder.
- Sub-module instr_word_fmt: purely combinational (op, rd, rs, imm) → {prep_word, op_word, needs_prep, illegal}. The FSM stays in instr_encoder.

Test Plan:
- LW rd=2 rs=5 imm=0x2A, instr_ready=1 → 0x02A then 0x095; prep_active remains 0; words_emitted=2.
- INC rd=3, then DEC rd=3 → 0x059, then 0x058; no PREP emitted; req_ready low exactly 1 cycle per op.
- PSFT rd=1 rs=0 imm=0x05, then ANDI rd=4 rs=2 imm=0x3F:
  - Output is 0x005, 0x148, then 0x022 with no second PREP.
  - prep_active=1 after 0x148 and 0 after 0x022.
- After PXOR, request XOR rd=1 rs=1 → err pulses exactly 1 cycle, no word emitted, prep_active stays 1. Also req_op=7 in prep_active=0 → err, no word.
- SW rd=0 rs=7 imm=0x10 with instr_ready held low 3 cycles on each word → instr stable at 0x010 then 0x0C7; req_ready stays 0 throughout; exactly 2 handshakes.
- Assert reset while in EMIT_OP after 0x02A was accepted → next cycle all outputs 0; no 0x095 ever emitted; the next request encodes normally.
